// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes
// and the datapath select/control codes.
package rv32i_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format implied by the opcode alone.
  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// funct3/funct7 to ALU operation decode for the execute states.
module alu_decoder
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [2:0] alu_control,
  output logic       legal
);

  // SUB exists only for R-type; an I-type with bit 30 set is still ADDI.
  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct3)
      3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_control = ALU_AND;
      3'b110:  alu_control = ALU_OR;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I subset control unit. Outputs depend on the current state
// plus instr/zero/mem_ready, and are all forced low while rst is high.
//
// state     | meaning
// ----------|------------------------------------------------
// FETCH     | read instr at PC, on ready load IR and PC <= PC+4
// DECODE    | ALUOut <= OldPC+imm (branch/jal target), dispatch
// MEMADR    | ALUOut <= A+imm (load/store address)
// MEMREAD   | read data at ALUOut until mem_ready
// MEMWB     | rd <= Data
// MEMWRITE  | write B at ALUOut until mem_ready
// EXECR     | ALUOut <= A op B
// EXECI     | ALUOut <= A op imm
// ALUWB     | rd <= ALUOut
// BRANCH    | compare A-B, PC <= ALUOut if taken
// JAL       | PC <= ALUOut
// JALR      | PC <= A+imm
// LINK      | rd <= OldPC+4
// TRAP      | unsupported instruction, parked until reset
module multicycle_ctrl
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic        illegal_instr
);

  state_t     state, next_state;
  logic       illegal_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] dec_alu;
  logic       dec_legal;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7_5    (instr[30]),
    .is_rtype    (opcode == OP_RTYPE),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  // State register and sticky illegal flag (set on entry to TRAP).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    next_state = S_FETCH;
      S_EXECR,
      S_EXECI:    next_state = dec_legal ? S_ALUWB : S_TRAP;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = (funct3 == 3'b000 || funct3 == 3'b001) ? S_FETCH : S_TRAP;
      S_JAL,
      S_JALR:     next_state = S_LINK;
      S_LINK:     next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  // Per-state datapath controls; rst overrides everything to zero.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_B;
    result_src  = RES_ALUOUT;
    alu_control = ALU_ADD;
    imm_src     = imm_src_of(opcode);
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_A;
        alu_control = dec_alu;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = SRCA_A;
        alu_control = ALU_SUB;
        pc_write    = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
      end
      S_JAL: pc_write = 1'b1;
      S_JALR: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
      end
      S_LINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_B;
      result_src  = RES_ALUOUT;
      alu_control = ALU_ADD;
      imm_src     = IMM_I;
    end
  end

  assign illegal_instr = illegal_q & ~rst;

endmodule
